// File: rtl/display_pkg.sv
// Shared defaults and helpers for the display source sequencer.
// Digit codes are DW-bit values rendered by the downstream hex decoders.
package display_pkg;

    localparam int DW_DEF = 4;
    localparam logic [DW_DEF-1:0] BLANK_DEF = 4'hF;

    typedef logic [DW_DEF-1:0] digit_t;

    function automatic int sel_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/display_source_sequencer_next_valid_finder.sv
// Wrapping upward priority search for the next valid source after cur.
// cur itself is never a candidate, so a lone valid source reports found=0.
module next_valid_finder #(
    parameter int N_SRC = 4,
    parameter int SW    = 2
) (
    input  logic [SW-1:0]    cur,
    input  logic [N_SRC-1:0] valid,
    output logic [SW-1:0]    nxt,
    output logic             found
);

    logic [SW-1:0]    cand [N_SRC-1:1];
    logic [N_SRC-1:1] hit;

    generate
        for (genvar gi = 1; gi < N_SRC; gi++) begin : g_off
            logic [SW:0] sum;
            assign sum       = {1'b0, cur} + (SW+1)'(gi);
            assign cand[gi]  = (sum >= (SW+1)'(N_SRC)) ? SW'(sum - (SW+1)'(N_SRC)) : sum[SW-1:0];
            assign hit[gi]   = valid[cand[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        for (int k = N_SRC - 1; k >= 1; k--) begin
            if (hit[k]) begin
                nxt   = cand[k];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_source_sequencer.sv
// Selects one of N_SRC digit groups and drives registered digit/indicator
// codes, with stepping, direct load, timed auto-cycle, blink and zero blanking.
module display_source_sequencer
    import display_pkg::*;
#(
    parameter int               N_SRC    = 4,
    parameter int               N_DIG    = 4,
    parameter int               DW       = DW_DEF,
    parameter logic [DW-1:0]    BLANK    = BLANK_DEF,
    parameter int               DWELL    = 5,
    parameter int               LZ_BLANK = 1,
    localparam int              SW       = sel_width(N_SRC)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC*N_DIG*DW-1:0]   src_data,
    input  logic [N_SRC-1:0]            src_valid,
    input  logic [N_SRC*DW-1:0]         src_ind,
    input  logic                        step,
    input  logic                        sel_load,
    input  logic [SW-1:0]               sel_in,
    input  logic                        auto_en,
    input  logic                        tick,
    input  logic [N_DIG-1:0]            blink_mask,
    output logic [DW-1:0]               hex,
    output logic [N_DIG*DW-1:0]         digits,
    output logic [SW-1:0]               sel_cur,
    output logic                        switched
);

    localparam int         WW         = N_DIG * DW;
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    logic [SW-1:0] sel_q, sel_d;
    logic [7:0]    dwell_q, dwell_d;
    logic          blink_q, blink_d;
    logic          switched_q, switched_d;
    logic [DW-1:0] hex_q, hex_d;
    logic [WW-1:0] digits_q, digits_d;

    logic [SW-1:0] nxt_idx;
    logic          nxt_found;
    logic          load_ok;

    next_valid_finder #(
        .N_SRC (N_SRC),
        .SW    (SW)
    ) u_finder (
        .cur   (sel_q),
        .valid (src_valid),
        .nxt   (nxt_idx),
        .found (nxt_found)
    );

    assign load_ok = (int'(sel_in) < N_SRC) && src_valid[sel_in];

    always_comb begin
        sel_d   = sel_q;
        dwell_d = dwell_q;
        blink_d = blink_q ^ tick;
        if (sel_load) begin
            dwell_d = '0;
            if (load_ok) begin
                sel_d = sel_in;
            end
        end else if (step) begin
            dwell_d = '0;
            if (nxt_found) begin
                sel_d = nxt_idx;
            end
        end else if (!auto_en) begin
            dwell_d = '0;
        end else if (tick) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                if (nxt_found) begin
                    sel_d = nxt_idx;
                end
            end else begin
                dwell_d = dwell_q + 8'd1;
            end
        end
        switched_d = (sel_d != sel_q);
    end

    logic [WW-1:0] src_word    [N_SRC];
    logic [DW-1:0] src_ind_arr [N_SRC];
    logic [WW-1:0] cur_word;
    logic          cur_valid;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign src_word[gi]    = src_data[gi*WW +: WW];
            assign src_ind_arr[gi] = src_ind[gi*DW +: DW];
        end
    endgenerate

    assign cur_word  = src_word[sel_q];
    assign cur_valid = src_valid[sel_q];
    assign hex_d     = cur_valid ? src_ind_arr[sel_q] : BLANK;

    // A digit is a leading zero when it and every more significant digit are zero.
    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
            logic lead_zero;
            always_comb begin
                lead_zero = (gi > 0) && (LZ_BLANK != 0);
                for (int k = gi; k < N_DIG; k++) begin
                    if (cur_word[k*DW +: DW] != '0) begin
                        lead_zero = 1'b0;
                    end
                end
            end
            assign digits_d[gi*DW +: DW] =
                (!cur_valid || (blink_q && blink_mask[gi]) || lead_zero) ? BLANK : cur_word[gi*DW +: DW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= '0;
            dwell_q    <= '0;
            blink_q    <= 1'b0;
            switched_q <= 1'b0;
            hex_q      <= BLANK;
            digits_q   <= {N_DIG{BLANK}};
        end else begin
            sel_q      <= sel_d;
            dwell_q    <= dwell_d;
            blink_q    <= blink_d;
            switched_q <= switched_d;
            hex_q      <= hex_d;
            digits_q   <= digits_d;
        end
    end

    assign sel_cur  = sel_q;
    assign switched = switched_q;
    assign hex      = hex_q;
    assign digits   = digits_q;

endmodule

// File: tb/tb_display_source_sequencer.sv
// Directed bench for display_source_sequencer: expected outputs are queued
// as each step is driven and popped for comparison after the clock edge.
module tb_display_source_sequencer;
    import display_pkg::*;

    localparam int N_SRC = 4;
    localparam int N_DIG = 4;
    localparam int DW    = 4;
    localparam int SW    = 2;

    logic                      clk;
    logic                      rst;
    logic [N_SRC*N_DIG*DW-1:0] src_data;
    logic [N_SRC-1:0]          src_valid;
    logic [N_SRC*DW-1:0]       src_ind;
    logic                      step;
    logic                      sel_load;
    logic [SW-1:0]             sel_in;
    logic                      auto_en;
    logic                      tick;
    logic [N_DIG-1:0]          blink_mask;
    logic [DW-1:0]             hex;
    logic [N_DIG*DW-1:0]       digits;
    logic [SW-1:0]             sel_cur;
    logic                      switched;

    display_source_sequencer #(
        .N_SRC    (N_SRC),
        .N_DIG    (N_DIG),
        .DW       (DW),
        .BLANK    (4'hF),
        .DWELL    (5),
        .LZ_BLANK (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ind    (src_ind),
        .step       (step),
        .sel_load   (sel_load),
        .sel_in     (sel_in),
        .auto_en    (auto_en),
        .tick       (tick),
        .blink_mask (blink_mask),
        .hex        (hex),
        .digits     (digits),
        .sel_cur    (sel_cur),
        .switched   (switched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit m_ph;
    int m_prev_sel;

    string               q_tag [$];
    logic [SW-1:0]       q_sel [$];
    logic                q_sw  [$];
    digit_t              q_hex [$];
    logic [N_DIG*DW-1:0] q_dig [$];

    // Reference view of what the display should show for source s.
    function automatic logic [15:0] model_digits(input int s);
        logic [15:0] w;
        logic [15:0] r;
        logic [3:0]  dg;
        bit          leading;
        w       = src_data[s*16 +: 16];
        r       = 16'hFFFF;
        leading = 1'b1;
        if (src_valid[s]) begin
            for (int d = 3; d >= 0; d--) begin
                dg = w[d*4 +: 4];
                if (leading && dg == 4'h0 && d > 0) begin
                    r[d*4 +: 4] = 4'hF;
                end else begin
                    leading     = 1'b0;
                    r[d*4 +: 4] = dg;
                end
                if (m_ph && blink_mask[d]) r[d*4 +: 4] = 4'hF;
            end
        end
        return r;
    endfunction

    function automatic digit_t model_hex(input int s);
        return src_valid[s] ? src_ind[s*4 +: 4] : 4'hF;
    endfunction

    task automatic check_pop();
        string               t;
        logic [SW-1:0]       es;
        logic                ew;
        digit_t              eh;
        logic [N_DIG*DW-1:0] ed;
        t  = q_tag.pop_front();
        es = q_sel.pop_front();
        ew = q_sw.pop_front();
        eh = q_hex.pop_front();
        ed = q_dig.pop_front();
        checks++;
        assert (sel_cur === es) else begin
            failures++;
            $error("FAIL %s sel_cur got=%0d exp=%0d", t, sel_cur, es);
        end
        checks++;
        assert (switched === ew) else begin
            failures++;
            $error("FAIL %s switched got=%0b exp=%0b", t, switched, ew);
        end
        checks++;
        assert (hex === eh) else begin
            failures++;
            $error("FAIL %s hex got=%h exp=%h", t, hex, eh);
        end
        checks++;
        assert (digits === ed) else begin
            failures++;
            $error("FAIL %s digits got=%h exp=%h", t, digits, ed);
        end
        $display("step %-14s sel=%0d sw=%0b hex=%h digits=%h", t, sel_cur, switched, hex, digits);
    endtask

    // Drive one clock with the inputs currently set; exp_sel/exp_sw are the
    // selection state expected right after the edge.
    task automatic run(input string tag, input int exp_sel, input logic exp_sw);
        q_tag.push_back(tag);
        if (rst) begin
            q_sel.push_back('0);
            q_sw.push_back(1'b0);
            q_hex.push_back(4'hF);
            q_dig.push_back(16'hFFFF);
            m_ph       = 1'b0;
            m_prev_sel = 0;
        end else begin
            q_sel.push_back(SW'(exp_sel));
            q_sw.push_back(exp_sw);
            q_hex.push_back(model_hex(m_prev_sel));
            q_dig.push_back(model_digits(m_prev_sel));
            if (tick) m_ph = ~m_ph;
            m_prev_sel = exp_sel;
        end
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic direct(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        src_data   = {16'h9001, 16'h5678, 16'h1234, 16'h0042};
        src_ind    = 16'hDCBA;
        src_valid  = 4'b1111;
        step       = 1'b0;
        sel_load   = 1'b0;
        sel_in     = '0;
        auto_en    = 1'b0;
        tick       = 1'b0;
        blink_mask = '0;
        m_ph       = 1'b0;
        m_prev_sel = 0;
        @(posedge clk);
        #1;

        run("reset_a", 0, 1'b0);
        run("reset_b", 0, 1'b0);
        rst = 1'b0;
        run("lz_src0", 0, 1'b0);
        direct("lz_digits", digits, 16'hFF42);
        direct("lz_hex", {12'h0, hex}, 16'h000A);

        src_valid = 4'b1011;
        sel_in    = 2'd1;
        sel_load  = 1'b1;
        run("load1", 1, 1'b1);
        sel_load = 1'b0;
        run("hold1", 1, 1'b0);
        step = 1'b1;
        run("step_to3", 3, 1'b1);
        step = 1'b0;
        run("hold3", 3, 1'b0);
        direct("interior_zero", digits, 16'h9001);
        step = 1'b1;
        run("step_wrap0", 0, 1'b1);
        step = 1'b0;
        run("hold0", 0, 1'b0);
        sel_in   = 2'd2;
        sel_load = 1'b1;
        run("load_invalid", 0, 1'b0);
        sel_in = 2'd0;
        run("load_same", 0, 1'b0);
        sel_load = 1'b0;
        run("idle", 0, 1'b0);

        src_valid = 4'b1111;
        auto_en   = 1'b1;
        run("auto_on", 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            run("auto_tick", 0, 1'b0);
            tick = 1'b0;
            run("auto_gap", 0, 1'b0);
        end
        tick = 1'b1;
        run("auto_adv1", 1, 1'b1);
        tick = 1'b0;
        run("auto_gap", 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            run("auto_tick", 1, 1'b0);
            tick = 1'b0;
            run("auto_gap", 1, 1'b0);
        end
        step = 1'b1;
        run("step_clr", 2, 1'b1);
        step = 1'b0;
        run("auto_gap", 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            run("auto_tick", 2, 1'b0);
            tick = 1'b0;
            run("auto_gap", 2, 1'b0);
        end
        tick = 1'b1;
        run("auto_adv3", 3, 1'b1);
        tick = 1'b0;
        run("auto_gap", 3, 1'b0);

        auto_en = 1'b0;
        tick    = 1'b1;
        run("tick_no_auto", 3, 1'b0);
        tick     = 1'b0;
        sel_in   = 2'd1;
        sel_load = 1'b1;
        run("sel1", 1, 1'b1);
        sel_load   = 1'b0;
        blink_mask = 4'b0011;
        run("blink_off", 1, 1'b0);
        direct("blink_ph0", digits, 16'h1234);
        tick = 1'b1;
        run("blink_tick", 1, 1'b0);
        tick = 1'b0;
        run("blink_on", 1, 1'b0);
        direct("blink_ph1", digits, 16'h12FF);
        tick = 1'b1;
        run("blink_tick", 1, 1'b0);
        tick = 1'b0;
        run("blink_back", 1, 1'b0);
        direct("blink_ph0b", digits, 16'h1234);
        blink_mask = '0;

        src_valid = 4'b1101;
        run("valid_drop", 1, 1'b0);
        direct("drop_digits", digits, 16'hFFFF);
        direct("drop_hex", {12'h0, hex}, 16'h000F);
        src_valid = 4'b1111;
        run("valid_back", 1, 1'b0);

        sel_in   = 2'd3;
        sel_load = 1'b1;
        step     = 1'b1;
        run("load_wins", 3, 1'b1);
        sel_load = 1'b0;
        step     = 1'b0;
        run("hold3", 3, 1'b0);

        rst  = 1'b1;
        step = 1'b1;
        run("rst_step", 0, 1'b0);
        rst  = 1'b0;
        step = 1'b0;
        run("after_rst", 0, 1'b0);

        src_data[3:0] = 4'h7;
        run("data7", 0, 1'b0);
        src_data[3:0] = 4'h8;
        run("data8", 0, 1'b0);
        direct("data_track", digits, 16'hFF48);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
